// File: rtl/vga_render_pkg.sv
// Shared types and helpers for the data-memory VGA window renderer.
package vga_render_pkg;

    localparam int unsigned GRID_DIM  = 16;
    localparam int unsigned GRID_BITS = 256;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAW,
        DONE
    } state_t;

    typedef logic [2:0] colour_t;

    // Byte 0 bit 7 sits at the top-left cell, so the index counts down from the MSB.
    function automatic logic [7:0] cell_bit_index(input logic [3:0] r, input logic [3:0] c);
        return 8'd255 - {r, 4'b0000} - {4'b0000, c};
    endfunction

endpackage

// File: rtl/vga_cell_scanner.sv
// Nested cell/pixel counters walking the grid in screen raster order
// (px fastest, then cell column, then py, then cell row).
module vga_cell_scanner #(
    parameter int unsigned CELL_W = 7,
    parameter int unsigned PW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic          skip_row,
    output logic [3:0]    cell_row,
    output logic [3:0]    cell_col,
    output logic [PW-1:0] px_off,
    output logic [PW-1:0] py_off,
    output logic          last_pixel_c
);

    localparam logic [PW-1:0] PIX_LAST  = PW'(CELL_W - 1);
    localparam logic [3:0]    CELL_LAST = 4'(15);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cell_row <= '0;
            cell_col <= '0;
            px_off   <= '0;
            py_off   <= '0;
        end else if (skip_row) begin
            cell_row <= cell_row + 4'd1;
            cell_col <= '0;
            px_off   <= '0;
            py_off   <= '0;
        end else if (en) begin
            if (px_off == PIX_LAST) begin
                px_off <= '0;
                if (cell_col == CELL_LAST) begin
                    cell_col <= '0;
                    if (py_off == PIX_LAST) begin
                        py_off   <= '0;
                        cell_row <= cell_row + 4'd1;
                    end else begin
                        py_off <= py_off + PW'(1);
                    end
                end else begin
                    cell_col <= cell_col + 4'd1;
                end
            end else begin
                px_off <= px_off + PW'(1);
            end
        end
    end

    assign last_pixel_c = (cell_row == CELL_LAST) && (cell_col == CELL_LAST) &&
                          (px_off == PIX_LAST) && (py_off == PIX_LAST);

endmodule

// File: rtl/vga_mem_renderer.sv
// Renders the first 32 data-memory bytes as a 16x16 monochrome grid via pixel writes.
// Optional VGA_RENDER_DIRTY_ROW_EN: redraw only cell rows whose data changed.
module vga_mem_renderer
    import vga_render_pkg::*;
#(
    parameter int unsigned CELL_W    = 7,
    parameter int unsigned X_ORIGIN  = 24,
    parameter int unsigned Y_ORIGIN  = 4,
    parameter colour_t     FG_COLOUR = 3'b111,
    parameter colour_t     BG_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GRID_BITS-1:0] memory_first_32_bytes,
    input  logic                 refresh_req,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output colour_t              vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned PW        = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam logic [3:0]  LAST_CELL = 4'(GRID_DIM - 1);

    state_t               state, state_d;
    logic [GRID_BITS-1:0] snap;
    logic                 pending, pending_d;
    logic                 snap_load, sc_clear, sc_en, sc_skip;
    logic                 last_pixel_c, mem_diff_c;
    logic [3:0]           cell_row, cell_col;
    logic [PW-1:0]        px_off, py_off;
    logic [7:0]           x_d;
    logic [6:0]           y_d;
    colour_t              colour_d;
    logic                 plot_d, busy_d, done_d;

    vga_cell_scanner #(
        .CELL_W (CELL_W),
        .PW     (PW)
    ) u_scanner (
        .clk          (clk),
        .reset        (reset),
        .clear        (sc_clear),
        .en           (sc_en),
        .skip_row     (sc_skip),
        .cell_row     (cell_row),
        .cell_col     (cell_col),
        .px_off       (px_off),
        .py_off       (py_off),
        .last_pixel_c (last_pixel_c)
    );

    assign mem_diff_c = (memory_first_32_bytes != snap);

`ifdef VGA_RENDER_DIRTY_ROW_EN
    logic [GRID_DIM-1:0] dirty, row_diff_c;
    logic                force_full, row_start_c;

    for (genvar r = 0; r < GRID_DIM; r++) begin : g_row_diff
        assign row_diff_c[r] = snap[GRID_BITS-1-GRID_DIM*r -: GRID_DIM] !=
                               memory_first_32_bytes[GRID_BITS-1-GRID_DIM*r -: GRID_DIM];
    end

    assign row_start_c = (cell_col == 4'd0) && (px_off == '0) && (py_off == '0);

    // Reset/refresh redraws are full frames; pure data changes redraw only changed rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty      <= '0;
            force_full <= 1'b1;
        end else if (state == CAPTURE) begin
            dirty      <= force_full ? '1 : row_diff_c;
            force_full <= refresh_req;
        end else if (refresh_req) begin
            force_full <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state;
        pending_d = pending;
        snap_load = 1'b0;
        sc_clear  = 1'b0;
        sc_en     = 1'b0;
        sc_skip   = 1'b0;
        x_d       = vga_x;
        y_d       = vga_y;
        colour_d  = vga_colour;
        plot_d    = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (pending || refresh_req || mem_diff_c) begin
                    state_d   = CAPTURE;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            CAPTURE: begin
                pending_d = pending || refresh_req;
                snap_load = 1'b1;
                sc_clear  = 1'b1;
                state_d   = DRAW;
            end
            DRAW: begin
                // Live data only feeds the pending flag here; pixels come from snap.
                pending_d = pending || refresh_req || mem_diff_c;
`ifdef VGA_RENDER_DIRTY_ROW_EN
                if (row_start_c && !dirty[cell_row]) begin
                    sc_skip = 1'b1;
                    if (cell_row == LAST_CELL) state_d = DONE;
                end else
`endif
                begin
                    plot_d   = 1'b1;
                    x_d      = 8'(X_ORIGIN) + 8'(cell_col) * 8'(CELL_W) + 8'(px_off);
                    y_d      = 7'(Y_ORIGIN) + 7'(cell_row) * 7'(CELL_W) + 7'(py_off);
                    colour_d = snap[cell_bit_index(cell_row, cell_col)] ? FG_COLOUR : BG_COLOUR;
                    sc_en    = 1'b1;
                    if (last_pixel_c) state_d = DONE;
                end
            end
            DONE: begin
                pending_d = pending || refresh_req || mem_diff_c;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b1;
            snap       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            pending    <= pending_d;
            if (snap_load) snap <= memory_first_32_bytes;
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= colour_d;
            vga_plot   <= plot_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_vga_mem_renderer.sv
// Directed bench for vga_mem_renderer; a negedge monitor accumulates plot statistics.
module tb_vga_mem_renderer;

    localparam int FRAME_PLOTS = 12544;
`ifdef VGA_RENDER_DIRTY_ROW_EN
    localparam int DATA_PLOTS = 784;
`else
    localparam int DATA_PLOTS = 12544;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         refresh_req = 1'b0;
    logic [255:0] mem = '0;
    logic [7:0]   vga_x;
    logic [6:0]   vga_y;
    logic [2:0]   vga_colour;
    logic         vga_plot, busy, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int plots = 0, fg = 0, fg_win = 0, y_win = 0, dones = 0, idle_busy = 0;
    int b_plots, b_fg, b_fgw, b_yw, b_done, b_ib, d0;
    int win_y0 = 4, win_y1 = 10;
    logic       prev_plot = 1'b0;
    logic [7:0] first_x = '0, last_x = '0;
    logic [6:0] first_y = '0, last_y = '0;

    always #5 clk = ~clk;

    vga_mem_renderer #(
        .CELL_W    (7),
        .X_ORIGIN  (24),
        .Y_ORIGIN  (4),
        .FG_COLOUR (3'b111),
        .BG_COLOUR (3'b000)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .memory_first_32_bytes (mem),
        .refresh_req           (refresh_req),
        .vga_x                 (vga_x),
        .vga_y                 (vga_y),
        .vga_colour            (vga_colour),
        .vga_plot              (vga_plot),
        .busy                  (busy),
        .frame_done            (frame_done)
    );

    always @(negedge clk) begin
        if (vga_plot) begin
            plots++;
            if (!prev_plot) begin
                first_x = vga_x;
                first_y = vga_y;
            end
            last_x = vga_x;
            last_y = vga_y;
            if (vga_colour == 3'b111) begin
                fg++;
                if (vga_x >= 8'd24 && vga_x <= 8'd30 && int'(vga_y) >= win_y0 && int'(vga_y) <= win_y1)
                    fg_win++;
            end
            if (int'(vga_y) >= win_y0 && int'(vga_y) <= win_y1) y_win++;
        end
        if (frame_done) dones++;
        if (busy && !vga_plot) idle_busy++;
        prev_plot = vga_plot;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap_counts();
        b_plots = plots; b_fg = fg; b_fgw = fg_win; b_yw = y_win; b_done = dones; b_ib = idle_busy;
    endtask

    task automatic wait_done(input string tag);
        tick();
        for (int n = 0; n < 20000 && !frame_done; n++) tick();
        check(tag, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_plots(input string tag, input int n);
        for (int i = 0; i < 20000 && (plots - b_plots) < n; i++) tick();
        check(tag, 32'(plots - b_plots), 32'(n));
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_plot",   32'(vga_plot),   32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_x",      32'(vga_x),      32'd0);
        check("rst_y",      32'(vga_y),      32'd0);
        check("rst_colour", 32'(vga_colour), 32'd0);

        // Frame after reset with all-zero memory.
        snap_counts();
        reset = 1'b0;
        wait_done("f1_done");
        check("f1_plots",   32'(plots - b_plots),      32'(FRAME_PLOTS));
        check("f1_fg",      32'(fg - b_fg),            32'd0);
        check("f1_first_x", 32'(first_x),              32'd24);
        check("f1_first_y", 32'(first_y),              32'd4);
        check("f1_last_x",  32'(last_x),               32'd135);
        check("f1_last_y",  32'(last_y),               32'd115);
        check("f1_nonplot", 32'(idle_busy - b_ib),     32'd2);
        repeat (30) tick();
        check("f1_quiet_plots", 32'(plots - b_plots),  32'(FRAME_PLOTS));
        check("f1_one_done",    32'(dones - b_done),   32'd1);
        check("f1_idle_busy",   32'(busy),             32'd0);

        // Top-left cell set.
        snap_counts();
        mem[255:248] = 8'h80;
        wait_done("f2_done");
        check("f2_plots",  32'(plots - b_plots), 32'(DATA_PLOTS));
        check("f2_fg",     32'(fg - b_fg),       32'd49);
        check("f2_fg_win", 32'(fg_win - b_fgw),  32'd49);

        // Refresh redraw; data flips mid-frame plus two more refresh pulses.
        snap_counts();
        pulse_refresh();
        wait_plots("f3_plot100", 100);
        mem[247:240] = 8'hFF;
        repeat (50) tick();
        pulse_refresh();
        repeat (50) tick();
        pulse_refresh();
        wait_done("f3_done");
        check("f3_plots", 32'(plots - b_plots), 32'(FRAME_PLOTS));
        check("f3_fg",    32'(fg - b_fg),       32'd49);
        snap_counts();
        tick();
        if (!busy) tick();
        check("f4_start_busy", 32'(busy), 32'd1);
        wait_done("f4_done");
        check("f4_plots", 32'(plots - b_plots), 32'(FRAME_PLOTS));
        check("f4_fg",    32'(fg - b_fg),       32'd441);
        repeat (40) tick();
        check("f4_one_done",    32'(dones - b_done),  32'd1);
        check("f4_quiet_plots", 32'(plots - b_plots), 32'(FRAME_PLOTS));
        check("f4_idle_busy",   32'(busy),            32'd0);

        // Reset in the middle of a frame.
        d0 = dones;
        snap_counts();
        pulse_refresh();
        wait_plots("f5_plot5000", 5000);
        reset = 1'b1;
        tick();
        check("f5_abort_plot", 32'(vga_plot), 32'd0);
        check("f5_abort_busy", 32'(busy),     32'd0);
        reset = 1'b0;
        snap_counts();
        wait_done("f6_done");
        check("f6_plots",   32'(plots - b_plots), 32'(FRAME_PLOTS));
        check("f6_dones",   32'(dones - d0),      32'd1);
        check("f6_first_x", 32'(first_x),         32'd24);
        check("f6_first_y", 32'(first_y),         32'd4);

`ifdef VGA_RENDER_DIRTY_ROW_EN
        // Only cell row 5 changes.
        win_y0 = 39;
        win_y1 = 45;
        snap_counts();
        mem[175] = 1'b1;
        wait_done("f7_done");
        check("f7_plots",   32'(plots - b_plots),     32'd784);
        check("f7_y_win",   32'(y_win - b_yw),        32'd784);
        check("f7_fg_win",  32'(fg_win - b_fgw),      32'd49);
        check("f7_skips",   32'(idle_busy - b_ib - 2), 32'd15);
        repeat (20) tick();
        check("f7_one_done", 32'(dones - b_done),     32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
